// File: rtl/mor1kx_pcu_sampler_pkg.sv
`default_nettype none
// ============================================================================
// mor1kx_pcu_sampler_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the performance-counter sampler:
//   - SPR address of PCCR0 (PCCRn lives at PCCR0 + n)
//   - FSM state encoding
//   - sample record layout {data, idx, last}
//   - lowest-set-bit helper used to walk the counter mask
// Revision: 1.0 - initial release
// ============================================================================
package mor1kx_pcu_sampler_pkg;

    // Performance-counter SPR group 7, PCCR0 at offset 0.
    localparam logic [15:0] OR1K_SPR_PCCR0_ADDR = 16'h3800;

    localparam int SMP_W = 36;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  idx;
        logic        last;
    } sample_t;

    // Index of the lowest set bit; 0 when no bit is set (caller checks that).
    function automatic logic [2:0] lowest_idx(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mor1kx_pcu_sampler_fifo.sv
`default_nettype none
// ============================================================================
// mor1kx_pcu_sampler_fifo
// ----------------------------------------------------------------------------
// Sample buffer, first-word-fall-through. Read data is the head entry and
// stays stable until popped.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push_i, wdata_i     write strobe / data (accepted when not full or
//                       when a pop frees the slot in the same cycle)
//   pop_i               remove head entry (ignored when empty)
//   rdata_o             head entry
//   full_o, empty_o     occupancy flags
// Revision: 1.0 - initial release
// ============================================================================
module mor1kx_pcu_sampler_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign empty_o   = (wptr_q == rptr_q);
    assign full_o    = (wptr_q[AW] != rptr_q[AW]) &&
                       (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_do_push) wptr_q <= wptr_q + 1'b1;
            if (w_do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mor1kx_pcu_sampler.sv
`default_nettype none
// ============================================================================
// mor1kx_pcu_sampler
// ----------------------------------------------------------------------------
// Periodically sweeps the masked performance counters PCCRn over the SPR bus,
// optionally clears each one after reading, and streams {value, index, last}
// samples out through a small buffer.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   enable_i, period_i               sampling enable, cycles between sweeps
//   counter_mask_i, clear_on_read_i  counters to sample, clear after read
//   spr_*_o / spr_bus_ack_i, spr_dat_i   SPR master interface
//   smp_valid_o/smp_ready_i, smp_data_o, smp_idx_o, smp_last_o  sample stream
//   drop_cnt_o                       saturating count of samples lost to a full buffer
//   err_o                            sticky SPR ack-timeout flag
// Revision: 1.0 - initial release
// ============================================================================
module mor1kx_pcu_sampler
    import mor1kx_pcu_sampler_pkg::*;
#(
    parameter int OPTION_PERFCOUNTERS_NUM = 7,
    parameter int FIFO_DEPTH              = 4,
    parameter int ACK_TIMEOUT             = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [15:0] period_i,
    input  logic [7:0]  counter_mask_i,
    input  logic        clear_on_read_i,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic        spr_re_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    output logic        spr_sys_mode_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i,
    output logic        smp_valid_o,
    input  logic        smp_ready_i,
    output logic [31:0] smp_data_o,
    output logic [2:0]  smp_idx_o,
    output logic        smp_last_o,
    output logic [15:0] drop_cnt_o,
    output logic        err_o
);

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] timer_q;
    logic [15:0] tmo_q;
    logic [7:0]  pend_q;     // counters still to visit in this sweep
    logic [2:0]  idx_q;
    logic        last_q;
    logic        clr_q;

    logic [7:0]  w_idx_ok;
    logic [7:0]  w_sweep_mask;
    logic [2:0]  w_low;
    logic [7:0]  w_pend_rest;
    logic [15:0] w_period_ld;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_ack_rd;
    logic        w_push;
    logic        w_drop;
    logic        w_tmo;
    sample_t     w_wr_smp;
    sample_t     w_rd_smp;

    // Counters beyond the implemented range are never accessed.
    for (genvar g = 0; g < 8; g++) begin : g_idx_ok
        assign w_idx_ok[g] = (g <= OPTION_PERFCOUNTERS_NUM);
    end

    assign w_sweep_mask = counter_mask_i & w_idx_ok;
    assign w_low        = lowest_idx(pend_q);
    assign w_pend_rest  = pend_q & ~(8'd1 << w_low);
    assign w_period_ld  = (period_i == 16'd0) ? 16'd1 : period_i;

    assign w_pop    = smp_valid_o && smp_ready_i;
    assign w_ack_rd = (state_q == ST_READ) && spr_bus_ack_i;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign w_push   = w_ack_rd && (!w_full || w_pop);
    assign w_drop   = w_ack_rd && !w_push;
    assign w_tmo    = (tmo_q == TMO_LAST);

    assign w_wr_smp = '{data: spr_dat_i, idx: idx_q, last: last_q};

    // Only zero is ever written, and only in CLEAR.
    assign spr_dat_o      = 32'd0;
    assign spr_sys_mode_o = 1'b1;

    assign smp_valid_o = !w_empty;
    assign smp_data_o  = w_rd_smp.data;
    assign smp_idx_o   = w_rd_smp.idx;
    assign smp_last_o  = w_rd_smp.last;

    mor1kx_pcu_sampler_fifo #(
        .WIDTH (SMP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .wdata_i (w_wr_smp),
        .pop_i   (w_pop),
        .rdata_o (w_rd_smp),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 16'd0;
            tmo_q        <= 16'd0;
            pend_q       <= 8'd0;
            idx_q        <= 3'd0;
            last_q       <= 1'b0;
            clr_q        <= 1'b0;
            spr_access_o <= 1'b0;
            spr_we_o     <= 1'b0;
            spr_re_o     <= 1'b0;
            spr_addr_o   <= 16'd0;
            drop_cnt_o   <= 16'd0;
            err_o        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_WAIT;
                        timer_q <= w_period_ld;
                    end
                end
                ST_WAIT: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        timer_q <= (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
                        // The decrement lands on 1 this cycle: the sweep starts.
                        if (timer_q <= 16'd2) begin
                            state_q <= ST_NEXT;
                            pend_q  <= w_sweep_mask;
                            clr_q   <= clear_on_read_i;
                        end
                    end
                end
                ST_NEXT: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (pend_q == 8'd0) begin
                        state_q <= ST_WAIT;
                        timer_q <= w_period_ld;
                    end else begin
                        state_q      <= ST_READ;
                        idx_q        <= w_low;
                        pend_q       <= w_pend_rest;
                        // Nothing left after this one: it is the highest masked index.
                        last_q       <= (w_pend_rest == 8'd0);
                        tmo_q        <= 16'd0;
                        spr_access_o <= 1'b1;
                        spr_re_o     <= 1'b1;
                        spr_we_o     <= 1'b0;
                        spr_addr_o   <= OR1K_SPR_PCCR0_ADDR + {13'd0, w_low};
                    end
                end
                ST_READ: begin
                    if (spr_bus_ack_i) begin
                        if (w_drop && (drop_cnt_o != 16'hFFFF)) begin
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        end
                        if (w_push && clr_q) begin
                            state_q  <= ST_CLEAR;
                            spr_re_o <= 1'b0;
                            spr_we_o <= 1'b1;
                            tmo_q    <= 16'd0;
                        end else begin
                            state_q      <= ST_NEXT;
                            spr_access_o <= 1'b0;
                            spr_re_o     <= 1'b0;
                        end
                    end else if (w_tmo) begin
                        state_q      <= ST_NEXT;
                        err_o        <= 1'b1;
                        spr_access_o <= 1'b0;
                        spr_re_o     <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                ST_CLEAR: begin
                    if (spr_bus_ack_i || w_tmo) begin
                        state_q      <= ST_NEXT;
                        spr_access_o <= 1'b0;
                        spr_we_o     <= 1'b0;
                        if (!spr_bus_ack_i) err_o <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    spr_access_o <= 1'b0;
                    spr_we_o     <= 1'b0;
                    spr_re_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mor1kx_pcu_sampler.md
MOR1KX_PCU_SAMPLER -- requirements
Module: mor1kx_pcu_sampler

Interface
REQ-001 SHALL have parameter OPTION_PERFCOUNTERS_NUM, default 7, meaning highest counter index sampled.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of 2).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 16, meaning max cycles to wait for spr_bus_ack_i.
REQ-004 Ports: clk  in  1  sole clock; rst_n  in  1  reset, synchronous, active-low.
REQ-005 enable_i  in  1  sampling enable; period_i  in  16  cycles between sweeps; counter_mask_i  in  8  bit n selects PCCRn; clear_on_read_i  in  1  zero PCCRn after reading.
REQ-006 spr_access_o  out  1; spr_we_o  out  1; spr_re_o  out  1; spr_addr_o  out  16; spr_dat_o  out  32; spr_sys_mode_o  out  1  constant 1 (supervisor).
REQ-007 spr_bus_ack_i  in  1  responder ack; spr_dat_i  in  32  read data, valid on ack cycle.
REQ-008 smp_valid_o  out  1; smp_ready_i  in  1; smp_data_o  out  32  counter value; smp_idx_o  out  3  counter index; smp_last_o  out  1  final sample of sweep.
REQ-009 drop_cnt_o  out  16  saturating dropped-sample count; err_o  out  1  sticky ack-timeout flag.

Function
REQ-010 Timer SHALL load max(period_i,1) on IDLE->WAIT, decrement each cycle in WAIT; reaching 1 starts a sweep.
REQ-011 FSM states IDLE, WAIT, READ, CLEAR, NEXT; IDLE->WAIT when enable_i=1; WAIT->NEXT at timer expiry.
REQ-012 NEXT SHALL select lowest masked index above the last serviced index (sweep starts at index 0); none left -> WAIT (timer reloaded) if enable_i, else IDLE.
REQ-013 READ: spr_access_o=1, spr_re_o=1, spr_we_o=0, spr_addr_o=OR1K_SPR_PCCR0_ADDR+idx; held stable until ack; deasserted cycle after ack.
REQ-014 On read ack, sample {data,idx,last} SHALL be pushed if FIFO not full; if full, sample dropped, drop_cnt_o+1 (saturate 16'hFFFF), and CLEAR skipped.
REQ-015 CLEAR (clear_on_read_i=1 and sample pushed): spr_access_o=1, spr_we_o=1, spr_dat_o=0, same address, until ack; then NEXT.
REQ-016 No ack within ACK_TIMEOUT cycles of access start: abort access, set err_o, no push, proceed to NEXT.
REQ-017 smp_last_o SHALL be 1 for highest index set in counter_mask_i latched at sweep start; mask/clear_on_read latched at sweep start, period_i at timer load.
REQ-018 Stream: entry transfers when smp_valid_o & smp_ready_i; smp_* stable while valid & !ready; push and pop same cycle when full SHALL both succeed only if pop frees space first (full+pop+push: no drop).
REQ-019 counter_mask_i=0 at sweep start: no SPR accesses, return to WAIT.
REQ-020 enable_i=0 mid-sweep: current access completes (incl. CLEAR), then IDLE; FIFO contents retained.
REQ-021 Timer expiry not possible during sweep; timer reloads only on sweep completion.
REQ-022 Indices above OPTION_PERFCOUNTERS_NUM SHALL be ignored even if masked.

Reset
REQ-023 rst_n=0 at clk edge: FSM IDLE, FIFO empty, smp_valid_o=0, all spr_*_o=0 except spr_sys_mode_o=1, drop_cnt_o=0, err_o=0, timer=0.
REQ-024 Reset mid-access SHALL drop the access next cycle with no ack processed.

Structure
REQ-025 SPR addresses (OR1K_SPR_PCCR0_ADDR) and state encodings SHALL reside in the shared mor1kx-defines.v.
REQ-026 FIFO SHALL be sub-module mor1kx_pcu_sampler_fifo (width 36, depth FIFO_DEPTH, full/empty flags).

Verification
REQ-027 period=4, mask=8'h05, ack same cycle, PCCR0=10, PCCR2=20 -> samples (10,0,last=0),(20,2,last=1); first read 4 cycles after enable.
REQ-028 clear_on_read=1, mask=8'h02 -> read of PCCR1 followed by write 0 to addr PCCR0+1; subsequent sweep reads 0 plus new events.
REQ-029 smp_ready_i=0, mask=8'hFF, FIFO_DEPTH=4 -> 4 samples buffered, drop_cnt_o=4 after first sweep, no CLEAR writes for dropped indices.
REQ-030 spr_bus_ack_i stuck 0 -> access aborted after 16 cycles, err_o=1, sweep continues to next index.
REQ-031 enable_i falls during READ of idx 3, mask=8'h38 -> idx 3 sample pushed, no idx 4/5 access, FSM IDLE.
REQ-032 rst_n=0 during CLEAR -> spr_access_o=0 next cycle, all outputs at reset values.
